except_commit: RTL

//  Sits directly downstream of the MM-stage exception arbiter and consumes its except_req_t.

---
 rtl/except_commit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/except_commit.sv
// Exception/ERET commit: flushes the pipeline, pulses CP0 write strobes, and holds a fetch redirect until IF accepts it.
// Optional BadVAddr update is enabled by defining EXCEPT_COMMIT_BADVADDR_EN.

package except_commit_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;

  typedef struct packed {
    logic              valid;
    logic              eret;
    logic [CODE_W-1:0] code;
    logic [XLEN-1:0]   extra;
    logic [XLEN-1:0]   pc;
    logic              delayslot;
    logic [XLEN-1:0]   except_vec;
  } except_req_t;
endpackage

module except_commit
  import except_commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              rst,
  input  except_req_t       except_req,
  input  logic              status_exl,
  input  logic              status_erl,
  output logic              flush,
  output logic              busy,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ready,
  output logic              exc_we,
  output logic [4:0]        exc_code,
  output logic              epc_we,
  output logic [31:0]       epc_wdata,
  output logic              cause_bd,
  output logic              eret_we,
  output logic              erl_clr,
  output logic              badvaddr_we,
  output logic [31:0]       badvaddr_wdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              exc_we_q, exc_we_d;
  logic [CODE_W-1:0] exc_code_q, exc_code_d;
  logic              epc_we_q, epc_we_d;
  logic [XLEN-1:0]   epc_wdata_q, epc_wdata_d;
  logic              cause_bd_q, cause_bd_d;
  logic              eret_we_q, eret_we_d;
  logic              erl_clr_q, erl_clr_d;

  logic accept_c;
  logic take_exc_c;
  logic take_eret_c;

  // A request is only sampled while idle; anything arriving while busy is dropped.
  assign accept_c    = (state_q == IDLE) && except_req.valid;
  assign take_exc_c  = accept_c && !except_req.eret;
  assign take_eret_c = accept_c &&  except_req.eret;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (except_req.valid) state_d = FLUSH;
      FLUSH:    state_d = redirect_ready ? IDLE : REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: computed one cycle ahead so every output leaves a flop
  always_comb begin
    flush_d          = accept_c;
    busy_d           = (state_d != IDLE);
    redirect_valid_d = (state_d != IDLE);
    redirect_pc_d    = redirect_pc_q;
    exc_we_d         = take_exc_c;
    exc_code_d       = exc_code_q;
    epc_we_d         = take_exc_c && !status_exl;
    epc_wdata_d      = epc_wdata_q;
    cause_bd_d       = cause_bd_q;
    eret_we_d        = take_eret_c;
    erl_clr_d        = erl_clr_q;

    if (accept_c) begin
      redirect_pc_d = except_req.except_vec;
    end
    // Data fields follow the most recent exception so they are stable under the strobe
    if (take_exc_c) begin
      exc_code_d  = except_req.code;
      cause_bd_d  = except_req.delayslot;
      epc_wdata_d = except_req.delayslot ? (except_req.pc - 32'd4) : except_req.pc;
    end
    if (take_eret_c) begin
      erl_clr_d = status_erl;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      exc_we_q         <= 1'b0;
      exc_code_q       <= '0;
      epc_we_q         <= 1'b0;
      epc_wdata_q      <= '0;
      cause_bd_q       <= 1'b0;
      eret_we_q        <= 1'b0;
      erl_clr_q        <= 1'b0;
    end else begin
      flush_q          <= flush_d;
      busy_q           <= busy_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      exc_we_q         <= exc_we_d;
      exc_code_q       <= exc_code_d;
      epc_we_q         <= epc_we_d;
      epc_wdata_q      <= epc_wdata_d;
      cause_bd_q       <= cause_bd_d;
      eret_we_q        <= eret_we_d;
      erl_clr_q        <= erl_clr_d;
    end
  end

`ifdef EXCEPT_COMMIT_BADVADDR_EN
  logic            badvaddr_we_q, badvaddr_we_d;
  logic [XLEN-1:0] badvaddr_wdata_q, badvaddr_wdata_d;
  logic            addr_code_c;

  // Mod, TLBL, TLBS, AdEL, AdES carry a faulting address in extra
  assign addr_code_c = (except_req.code >= 5'd1) && (except_req.code <= 5'd5);

  always_comb begin
    badvaddr_we_d    = take_exc_c && addr_code_c;
    badvaddr_wdata_d = badvaddr_wdata_q;
    if (badvaddr_we_d) begin
      badvaddr_wdata_d = except_req.extra;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_we_q    <= 1'b0;
      badvaddr_wdata_q <= '0;
    end else begin
      badvaddr_we_q    <= badvaddr_we_d;
      badvaddr_wdata_q <= badvaddr_wdata_d;
    end
  end

  assign badvaddr_we    = badvaddr_we_q;
  assign badvaddr_wdata = badvaddr_wdata_q;
`else
  logic unused_extra;
  assign unused_extra   = ^except_req.extra;
  assign badvaddr_we    = 1'b0;
  assign badvaddr_wdata = '0;
`endif

  assign flush          = flush_q;
  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign exc_we         = exc_we_q;
  assign exc_code       = exc_code_q;
  assign epc_we         = epc_we_q;
  assign epc_wdata      = epc_wdata_q;
  assign cause_bd       = cause_bd_q;
  assign eret_we        = eret_we_q;
  assign erl_clr        = erl_clr_q;

endmodule
